// File: rtl/board_ctrl_pkg.sv
// Shared encodings and helpers for the tic-tac-toe board controller.
// Cell, winner and state codes plus the win-line table live here.
package board_ctrl_pkg;

    typedef logic [1:0] cell_t;
    typedef cell_t [8:0] board_t;

    localparam cell_t CELL_EMPTY = 2'd0;
    localparam cell_t CELL_P1    = 2'd1;
    localparam cell_t CELL_P2    = 2'd2;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam logic [1:0] S_PLAY  = 2'd0;
    localparam logic [1:0] S_CHECK = 2'd1;
    localparam logic [1:0] S_OVER  = 2'd2;

    localparam logic [2:0] DEF_EMPTY_COLOR  = 3'b111;
    localparam logic [2:0] DEF_P1_COLOR     = 3'b100;
    localparam logic [2:0] DEF_P2_COLOR     = 3'b001;
    localparam logic [2:0] DEF_CURSOR_COLOR = 3'b010;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_PLACE,
        ACT_UP,
        ACT_DOWN,
        ACT_LEFT,
        ACT_RIGHT
    } act_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
    } line_t;

    // Cell indices of the 8 winning lines (rows, cols, diagonals).
    function automatic line_t win_line(input logic [2:0] i);
        line_t l;
        unique case (i)
            3'd0: l = '{4'd0, 4'd1, 4'd2};
            3'd1: l = '{4'd3, 4'd4, 4'd5};
            3'd2: l = '{4'd6, 4'd7, 4'd8};
            3'd3: l = '{4'd0, 4'd3, 4'd6};
            3'd4: l = '{4'd1, 4'd4, 4'd7};
            3'd5: l = '{4'd2, 4'd5, 4'd8};
            3'd6: l = '{4'd0, 4'd4, 4'd8};
            3'd7: l = '{4'd2, 4'd4, 4'd6};
        endcase
        return l;
    endfunction

    // True when mark m fills any complete line of board b.
    function automatic logic owns_line(input board_t b, input cell_t m);
        logic  hit;
        line_t l;
        hit = 1'b0;
        for (int i = 0; i < 8; i++) begin
            l = win_line(3'(i));
            if (b[l.a] == m && b[l.b] == m && b[l.c] == m)
                hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/board_ctrl_btn_edge.sv
// Rising-edge detector for one synchronised button level.
// Pulse is high for the single cycle where level=1 and last level=0.
module board_ctrl_btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic prev;

    // Remember the previous level to spot 0->1 transitions.
    always_ff @(posedge clk) begin
        if (rst)
            prev <= 1'b0;
        else
            prev <= level;
    end

    assign pulse = level & ~prev;

endmodule

// File: rtl/board_ctrl.sv
// Tic-tac-toe game-state engine: cursor, marks, turns, win/draw.
// Drives nine registered cell colours for the grid display stage.
module board_ctrl
    import board_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter logic [2:0]  EMPTY_COLOR  = DEF_EMPTY_COLOR,
    parameter logic [2:0]  P1_COLOR     = DEF_P1_COLOR,
    parameter logic [2:0]  P2_COLOR     = DEF_P2_COLOR,
    parameter logic [2:0]  CURSOR_COLOR = DEF_CURSOR_COLOR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_place,
    output logic [2:0] A1_color,
    output logic [2:0] A2_color,
    output logic [2:0] A3_color,
    output logic [2:0] B1_color,
    output logic [2:0] B2_color,
    output logic [2:0] B3_color,
    output logic [2:0] C1_color,
    output logic [2:0] C2_color,
    output logic [2:0] C3_color,
    output logic       turn,
    output logic [1:0] winner,
    output logic       game_over
);

    localparam int unsigned CW =
        (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_CYCLES - 1);

    logic          up_edge;
    logic          down_edge;
    logic          left_edge;
    logic          right_edge;
    logic          place_edge;
    act_t          act;
    logic [1:0]    state;
    board_t        board;
    logic [1:0]    row;
    logic [1:0]    col;
    logic [3:0]    cur_idx;
    logic [3:0]    move_count;
    cell_t         mover;
    logic [CW-1:0] blink_cnt;
    logic          phase;
    logic          show_cursor;
    logic [8:0][2:0] color_d;
    logic [8:0][2:0] color_q;

    board_ctrl_btn_edge u_up (
        .clk(clk), .rst(rst), .level(btn_up), .pulse(up_edge)
    );
    board_ctrl_btn_edge u_down (
        .clk(clk), .rst(rst), .level(btn_down), .pulse(down_edge)
    );
    board_ctrl_btn_edge u_left (
        .clk(clk), .rst(rst), .level(btn_left), .pulse(left_edge)
    );
    board_ctrl_btn_edge u_right (
        .clk(clk), .rst(rst), .level(btn_right), .pulse(right_edge)
    );
    board_ctrl_btn_edge u_place (
        .clk(clk), .rst(rst), .level(btn_place), .pulse(place_edge)
    );

    assign cur_idx = {2'b00, row} * 4'd3 + {2'b00, col};
    assign mover   = turn ? CELL_P2 : CELL_P1;

    // Resolve simultaneous edges to one action: place > up > down > left > right.
    always_comb begin
        act = ACT_NONE;
        if (place_edge)
            act = ACT_PLACE;
        else if (up_edge)
            act = ACT_UP;
        else if (down_edge)
            act = ACT_DOWN;
        else if (left_edge)
            act = ACT_LEFT;
        else if (right_edge)
            act = ACT_RIGHT;
    end

    // Game FSM: cursor moves, mark placement, line check, restart.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_PLAY;
            board      <= '0;
            row        <= 2'd0;
            col        <= 2'd0;
            turn       <= 1'b0;
            winner     <= WIN_NONE;
            move_count <= 4'd0;
        end else begin
            unique case (state)
                S_PLAY: begin
                    case (act)
                        ACT_UP:
                            row <= (row == 2'd0) ? 2'd2 : row - 2'd1;
                        ACT_DOWN:
                            row <= (row == 2'd2) ? 2'd0 : row + 2'd1;
                        ACT_LEFT:
                            col <= (col == 2'd0) ? 2'd2 : col - 2'd1;
                        ACT_RIGHT:
                            col <= (col == 2'd2) ? 2'd0 : col + 2'd1;
                        ACT_PLACE: begin
                            if (board[cur_idx] == CELL_EMPTY) begin
                                board[cur_idx] <= mover;
                                if (move_count != 4'd9)
                                    move_count <= move_count + 4'd1;
                                state <= S_CHECK;
                            end
                        end
                        default: ;
                    endcase
                end
                S_CHECK: begin
                    if (owns_line(board, mover)) begin
                        winner <= turn ? WIN_P2 : WIN_P1;
                        state  <= S_OVER;
                    end else if (move_count == 4'd9) begin
                        winner <= WIN_DRAW;
                        state  <= S_OVER;
                    end else begin
                        turn  <= ~turn;
                        state <= S_PLAY;
                    end
                end
                S_OVER: begin
                    if (act == ACT_PLACE) begin
                        board      <= '0;
                        move_count <= 4'd0;
                        turn       <= 1'b0;
                        winner     <= WIN_NONE;
                        row        <= 2'd0;
                        col        <= 2'd0;
                        state      <= S_PLAY;
                    end
                end
                default: state <= S_PLAY;
            endcase
        end
    end

    // Free-running blink timer; phase flips once per half-period.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    function automatic logic [2:0] cell_color(input cell_t c);
        logic [2:0] rgb;
        case (c)
            CELL_P1: rgb = P1_COLOR;
            CELL_P2: rgb = P2_COLOR;
            default: rgb = EMPTY_COLOR;
        endcase
        return rgb;
    endfunction

    assign show_cursor = phase && (state != S_OVER);

    // Map board contents to colours, overlaying the blinking cursor.
    always_comb begin
        color_d = '0;
        for (int i = 0; i < 9; i++) begin
            color_d[i] = cell_color(board[i]);
            if (show_cursor && cur_idx == 4'(i))
                color_d[i] = CURSOR_COLOR;
        end
    end

    // Register the colours so the display sees glitch-free values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 9; i++)
                color_q[i] <= EMPTY_COLOR;
        end else begin
            color_q <= color_d;
        end
    end

    assign A1_color  = color_q[0];
    assign A2_color  = color_q[1];
    assign A3_color  = color_q[2];
    assign B1_color  = color_q[3];
    assign B2_color  = color_q[4];
    assign B3_color  = color_q[5];
    assign C1_color  = color_q[6];
    assign C2_color  = color_q[7];
    assign C3_color  = color_q[8];
    assign game_over = (state == S_OVER);

endmodule
